// File: rtl/regfile_bank.sv
// regfile_bank: parametrised integer register file with hardwired-zero x0,
// per-byte write enables and a sequential soft-clear sweep.
// Ports: clk, reset_rf (async, active-high); write port we/wbe/adr3/wdata;
// combinational read ports adr1->rd1, adr2->rd2; clear control clr_req in,
// clr_busy/clr_done out. Define REGFILE_BYPASS_EN for read-during-write forwarding.
module regfile_bank #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_rf,
    input  logic              we,
    input  logic [XLEN/8-1:0] wbe,
    input  logic [AW-1:0]     adr1,
    input  logic [AW-1:0]     adr2,
    input  logic [AW-1:0]     adr3,
    input  logic [XLEN-1:0]   wdata,
    input  logic              clr_req,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    output logic              clr_busy,
    output logic              clr_done
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   cnt, cnt_n;
    logic [XLEN-1:0] rf [NREGS];
    logic            wr_ok;
    logic [XLEN-1:0] src1, src2;

    assign wr_ok = we && state != CLEAR && adr3 != '0;

    always_ff @(posedge clk or posedge reset_rf) begin
        if (reset_rf) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            clr_busy <= state_n == CLEAR;
            clr_done <= state_n == DONE;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (clr_req) begin
                state_n = CLEAR;
                cnt_n   = AW'(1);
            end
            CLEAR: begin
                cnt_n   = cnt + AW'(1);
                state_n = cnt == AW'(NREGS - 1) ? DONE : CLEAR;
            end
            default: state_n = IDLE;
        endcase
    end

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset_rf) begin
        if (reset_rf) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (state == CLEAR) begin
            rf[cnt] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < XLEN/8; b++)
                if (wbe[b]) rf[adr3][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [XLEN-1:0] merged;

    always_comb begin
        merged = rf[adr3];
        for (int b = 0; b < XLEN/8; b++)
            if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end

    assign src1 = wr_ok && adr1 == adr3 ? merged : rf[adr1];
    assign src2 = wr_ok && adr2 == adr3 ? merged : rf[adr2];
`else
    assign src1 = rf[adr1];
    assign src2 = rf[adr2];
`endif

    // The sweep forces reads to zero ahead of the bypass.
    assign rd1 = state == CLEAR || adr1 == '0 ? '0 : src1;
    assign rd2 = state == CLEAR || adr2 == '0 ? '0 : src2;
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed self-checking bench for regfile_bank at default parameters.
module tb_regfile_bank;
    logic        clk = 1'b0;
    logic        reset_rf = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  wbe = 4'h0;
    logic [4:0]  adr1 = '0, adr2 = '0, adr3 = '0;
    logic [31:0] wdata = '0;
    logic        clr_req = 1'b0;
    logic [31:0] rd1, rd2;
    logic        clr_busy, clr_done;
    int          tests = 0, fails = 0;
    int          busy_cnt, done_cnt, done_at, nz;

    regfile_bank dut (
        .clk(clk), .reset_rf(reset_rf), .we(we), .wbe(wbe),
        .adr1(adr1), .adr2(adr2), .adr3(adr3), .wdata(wdata),
        .clr_req(clr_req), .rd1(rd1), .rd2(rd2),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; adr3 = a; wdata = d; wbe = be;
        step();
        we = 1'b0;
    endtask

    initial begin
        adr1 = 5'd5;
        #1;
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_busy", 32'(clr_busy), 32'h0);
        chk("reset_done", 32'(clr_done), 32'h0);
        #1 reset_rf = 1'b0;

        wr(5'd5, 32'hDEADBEEF, 4'hF);
        chk("load_r5", rd1, 32'hDEADBEEF);
        #1 reset_rf = 1'b1;
        #1;
        chk("async_reset_r5", rd1, 32'h0);
        chk("async_reset_busy", 32'(clr_busy), 32'h0);
        chk("async_reset_done", 32'(clr_done), 32'h0);
        #1 reset_rf = 1'b0;

        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        adr1 = 5'd0; #1;
        chk("x0_read", rd1, 32'h0);

        wr(5'd7, 32'h11223344, 4'hF);
        wr(5'd7, 32'hAABBCCDD, 4'b0101);
        adr1 = 5'd7; #1;
        chk("byte_merge_r7", rd1, 32'h11BB33DD);
        wr(5'd7, 32'h99999999, 4'h0);
        chk("wbe_zero_noop", rd1, 32'h11BB33DD);

        wr(5'd3, 32'h11223344, 4'hF);
        we = 1'b1; adr3 = 5'd3; wbe = 4'hF; wdata = 32'h0000CAFE; adr2 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_pre_edge", rd2, 32'h0000CAFE);
`else
        chk("bypass_pre_edge", rd2, 32'h11223344);
`endif
        step();
        we = 1'b0;
        chk("bypass_post_edge", rd2, 32'h0000CAFE);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5000000 | 32'(i), 4'hF);
        adr1 = 5'd31; adr2 = 5'd1; #1;
        chk("fill_r31", rd1, 32'hA500001F);
        chk("fill_r1", rd2, 32'hA5000001);

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("sweep_rd_forced", rd1, 32'h0);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) begin done_cnt++; done_at = c; end
            if (c == 3) begin we = 1'b1; adr3 = 5'd2; wdata = 32'h00000077; wbe = 4'hF; end
            if (c == 4) we = 1'b0;
            step();
        end
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'd31);
        chk("sweep_done_pulses", 32'(done_cnt), 32'd1);
        chk("sweep_done_cycle", 32'(done_at), 32'd31);
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            adr1 = 5'(i); #1;
            if (rd1 != 32'h0) nz++;
        end
        chk("sweep_all_zero", 32'(nz), 32'd0);
        adr1 = 5'd2; #1;
        chk("busy_write_lost", rd1, 32'h0);

        we = 1'b1; adr3 = 5'd9; wdata = 32'h5; wbe = 4'hF; clr_req = 1'b1;
        adr1 = 5'd9;
        step();
        we = 1'b0; clr_req = 1'b0;
        chk("simul_rd_forced", rd1, 32'h0);
        chk("simul_busy", 32'(clr_busy), 32'h1);
        repeat (35) step();
        chk("simul_r9_cleared", rd1, 32'h0);

        wr(5'd20, 32'h0000ABCD, 4'hF);
        adr1 = 5'd20; #1;
        chk("pre_abort_r20", rd1, 32'h0000ABCD);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        #1 reset_rf = 1'b1;
        #1;
        chk("abort_busy_drop", 32'(clr_busy), 32'h0);
        #1 reset_rf = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (clr_done) done_cnt++;
            step();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_r20_zero", rd1, 32'h0);

        wr(5'd4, 32'h00001234, 4'hF);
        adr2 = 5'd4; #1;
        chk("post_abort_write", rd2, 32'h00001234);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("restart_busy", 32'(clr_busy), 32'h1);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (clr_done) done_cnt++;
            step();
        end
        chk("restart_done_once", 32'(done_cnt), 32'd1);
        chk("restart_r4_zero", rd2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
